// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands, select and result are registered; mul/div hold the ALU for multiple cycles.
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [3:0]       alu_select,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  localparam logic [3:0] SEL_MUL  = 4'b0010;
  localparam logic [3:0] SEL_DIV  = 4'b0011;
  localparam logic [3:0] SEL_NONE = 4'b1111;
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            owner;
  logic [CW-1:0]   cnt;
  logic            gnt0, gnt1;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0]      sel_op;

  function automatic logic is_illegal(input logic [3:0] s);
    return (s == 4'b1001) || (s == 4'b1010) || (s == 4'b1101) || (s == 4'b1110);
  endfunction

  // Counter preload is latency minus one; div-by-zero short-circuits to one cycle.
  function automatic logic [CW-1:0] lat_m1(input logic [3:0] s, input logic [WIDTH-1:0] b);
    if (s == SEL_MUL)                 return CW'(MUL_LAT - 1);
    else if (s == SEL_DIV && b != '0) return CW'(DIV_LAT - 1);
    else                              return '0;
  endfunction

  // Tie goes to the port that did not win last; last_grant resets to 1 so port 0 wins first.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant);
    gnt1 = req1_valid && (!req0_valid || !last_grant);
  end

  always_comb begin
    sel_a  = gnt1 ? req1_a   : req0_a;
    sel_b  = gnt1 ? req1_b   : req0_b;
    sel_op = gnt1 ? req1_sel : req0_sel;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (gnt0 || gnt1) state_nxt = EXEC;
      EXEC: if (cnt == '0)    state_nxt = RESP;
      RESP:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Ready is gated by rst_n so nothing is accepted while reset is asserted.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && gnt0;
    req1_ready = rst_n && (state == IDLE) && gnt1;
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) && owner;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in0    <= '0;
      alu_in1    <= '0;
      alu_select <= SEL_NONE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (gnt0 || gnt1) begin
          alu_in0    <= sel_a;
          alu_in1    <= sel_b;
          alu_select <= sel_op;
          owner      <= gnt1;
          last_grant <= gnt1;
          cnt        <= lat_m1(sel_op, sel_b);
        end
        EXEC: if (cnt == '0) begin
          if (is_illegal(alu_select)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else if (alu_select == SEL_DIV && alu_in1 == '0) begin
            rsp_data <= '1;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_out;
            rsp_err  <= 1'b0;
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
        RESP: alu_select <= SEL_NONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_alu_arbiter;
  localparam int W  = 16;
  localparam int ML = 2;
  localparam int DL = 4;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                         OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SHL = 4'h7,
                         OP_SHR = 4'h8, OP_BAD = 4'h9;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0;
  logic req0_ready, req1_ready;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_sel = 0, req1_sel = 0;
  logic rsp0_valid, rsp1_valid, rsp_err, busy;
  logic [W-1:0] rsp_data, alu_in0, alu_in1, alu_out;
  logic [3:0] alu_select;

  alu_arbiter #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_select(alu_select), .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU; its select encoding is the bench's own choice.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    case (s)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_MUL: return a * b;
      OP_DIV: return (b == 0) ? '1 : a / b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SHL: return a << b[3:0];
      OP_SHR: return a >> b[3:0];
      default: return '0;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_in0, alu_in1, alu_select);

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op in flight, known start cycle and latency.
  int cyc = 0, m_start = 0, m_lat = 1;
  bit m_inflight = 0, m_last = 1, m_owner = 0, m_err = 0, m_held_err = 0, was_free;
  logic [W-1:0] m_a = 0, m_b = 0, m_data = 0, m_held = 0;
  logic [3:0] m_sel = 0;
  bit resp_now, exec_now, exp_rdy0, exp_rdy1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight = 0; m_last = 1; m_held = 0; m_held_err = 0;
    end else begin
      was_free = !m_inflight;
      cyc++;
      if (m_inflight && cyc == m_start + m_lat + 1) m_inflight = 0;
      if (was_free && (req0_valid || req1_valid)) begin
        m_owner = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_a   = m_owner ? req1_a   : req0_a;
        m_b   = m_owner ? req1_b   : req0_b;
        m_sel = m_owner ? req1_sel : req0_sel;
        if (m_sel inside {4'b1001, 4'b1010, 4'b1101, 4'b1110}) begin
          m_lat = 1; m_data = 0; m_err = 1;
        end else if (m_sel == OP_DIV && m_b == 0) begin
          m_lat = 1; m_data = 16'hFFFF; m_err = 1;
        end else begin
          m_lat  = (m_sel == OP_MUL) ? ML : (m_sel == OP_DIV) ? DL : 1;
          m_data = ref_alu(m_a, m_b, m_sel);
          m_err  = 0;
        end
        m_start = cyc; m_inflight = 1; m_last = m_owner;
      end
      if (m_inflight && cyc == m_start + m_lat) begin
        m_held = m_data; m_held_err = m_err;
      end
    end
  end

  always @(negedge clk) begin
    resp_now = m_inflight && cyc == m_start + m_lat;
    exec_now = m_inflight && cyc < m_start + m_lat;
    exp_rdy0 = rst_n && !m_inflight && req0_valid && (!req1_valid || m_last);
    exp_rdy1 = rst_n && !m_inflight && req1_valid && (!req0_valid || !m_last);
    check("busy", busy, m_inflight);
    check("ready0", req0_ready, exp_rdy0);
    check("ready1", req1_ready, exp_rdy1);
    check("rsp0_valid", rsp0_valid, resp_now && !m_owner);
    check("rsp1_valid", rsp1_valid, resp_now && m_owner);
    check("rsp_data", rsp_data, m_held);
    check("rsp_err", rsp_err, m_held_err);
    if (!m_inflight) check("alu_select_idle", alu_select, 4'hF);
    if (exec_now) begin
      check("alu_in0", alu_in0, m_a);
      check("alu_in1", alu_in1, m_b);
      check("alu_select", alu_select, m_sel);
    end
    if (!rst_n) begin
      check("alu_in0_rst", alu_in0, 0);
      check("alu_in1_rst", alu_in1, 0);
    end
  end

  // Observation of accepts and responses for literal checks.
  int tick = 0, acc_tick = 0, rsp0_tick = 0, rsp1_tick = 0, n0 = 0, n1 = 0;
  logic [W-1:0] last0 = 0, last1 = 0;
  logic lerr0 = 0, lerr1 = 0;

  always @(posedge clk) tick++;

  always @(negedge clk) begin
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_tick = tick + 1;
    if (rsp0_valid) begin n0++; last0 = rsp_data; lerr0 = rsp_err; rsp0_tick = tick; end
    if (rsp1_valid) begin n1++; last1 = rsp_data; lerr1 = rsp_err; rsp1_tick = tick; end
  end

  task automatic issue(input bit p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    bit done = 0;
    if (p) begin req1_a = a; req1_b = b; req1_sel = s; req1_valid = 1; end
    else   begin req0_a = a; req0_b = b; req0_sel = s; req0_valid = 1; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (p ? req1_ready : req0_ready) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout port %0d: ready never seen, expected within 50 cycles", p);
    end
    @(posedge clk); #1;
    if (p) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stuck, expected idle within 60 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  int n0_before, n1_before, k;
  int acc6[8];

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_select", alu_select, 4'hF);
    check("reset_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;

    // 1: single add
    issue(0, 13, 6, OP_ADD); wait_idle();
    check("t1_data", last0, 19);
    check("t1_err", lerr0, 0);
    check("t1_lat", rsp0_tick - acc_tick, 1);

    // 2: simultaneous requests after reset, then repeat the tie
    do_reset();
    for (int r = 0; r < 2; r++) begin
      fork
        issue(0, 13, 6, OP_SUB);
        issue(1, 13, 6, OP_XOR);
      join
      wait_idle();
      check("t2_data0", last0, 7);
      check("t2_data1", last1, 11);
      check("t2_order", rsp0_tick < rsp1_tick, 1);
    end

    // 3: multiply on port 1
    issue(1, 13, 6, OP_MUL); wait_idle();
    check("t3_data", last1, 78);
    check("t3_lat", rsp1_tick - acc_tick, ML);

    // 4: divide, divide by zero, illegal select
    issue(0, 13, 6, OP_DIV); wait_idle();
    check("t4_div_data", last0, 2);
    check("t4_div_err", lerr0, 0);
    check("t4_div_lat", rsp0_tick - acc_tick, DL);
    issue(1, 13, 0, OP_DIV); wait_idle();
    check("t4_div0_data", last1, 16'hFFFF);
    check("t4_div0_err", lerr1, 1);
    check("t4_div0_lat", rsp1_tick - acc_tick, 1);
    issue(0, 13, 6, OP_BAD); wait_idle();
    check("t4_bad_data", last0, 0);
    check("t4_bad_err", lerr0, 1);

    // 5: reset during div EXEC with cnt==2, then a shift
    n0_before = n0; n1_before = n1;
    issue(0, 13, 6, OP_DIV);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_data", rsp_data, 0);
    check("t5_select", alu_select, 4'hF);
    @(posedge clk); #1 rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_rsp", n0 + n1, n0_before + n1_before);
    issue(1, 13, 6, OP_SHL); wait_idle();
    check("t5_shl", last1, 832);

    // 6: eight back-to-back ands on port 0
    n0_before = n0; k = 0;
    req0_a = 13; req0_b = 6; req0_sel = OP_AND; req0_valid = 1;
    for (int i = 0; i < 100 && k < 8; i++) begin
      @(negedge clk);
      if (req0_ready) begin acc6[k] = tick + 1; k++; end
    end
    @(posedge clk); #1 req0_valid = 0;
    wait_idle();
    check("t6_accepts", k, 8);
    for (int i = 1; i < 8; i++) check("t6_spacing", acc6[i] - acc6[i-1], 3);
    check("t6_rsp_count", n0 - n0_before, 8);
    check("t6_data", last0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
